// File: rtl/nrisc_pkg.sv
// Shared definitions for the processor-side register bank sequencer:
// instruction classes, sequencer states and instruction field positions.
package nrisc_pkg;

  localparam int LARGURA = 8;
  localparam int NREG    = 8;
  localparam int REG_W   = $clog2(NREG);

  // Instruction class encodings (Instr[7:6]); RES behaves as NOP
  localparam logic [1:0] CLASSE_NOP  = 2'b00;
  localparam logic [1:0] CLASSE_ULA  = 2'b01;
  localparam logic [1:0] CLASSE_IMED = 2'b10;
  localparam logic [1:0] CLASSE_RES  = 2'b11;

  typedef enum logic [2:0] {
    OCIOSO,
    LEITURA,
    EXECUCAO,
    ESCRITA,
    RETIRA
  } estado_t;

  localparam int CLASSE_MSB = 7;
  localparam int CLASSE_LSB = 6;
  localparam int RA_MSB     = 5;
  localparam int RA_LSB     = 3;
  localparam int RB_MSB     = 2;
  localparam int RB_LSB     = 0;

endpackage

// File: rtl/decodificador_instr.sv
// Combinational split of an instruction word into class and register fields.
module decodificador_instr
  import nrisc_pkg::*;
(
  input  logic [7:0]       Instr,
  output logic [1:0]       Classe,
  output logic [REG_W-1:0] Ra,
  output logic [REG_W-1:0] Rb
);

  assign Classe = Instr[CLASSE_MSB:CLASSE_LSB];
  assign Ra     = Instr[RA_MSB:RA_LSB];
  assign Rb     = Instr[RB_MSB:RB_LSB];

endmodule

// File: rtl/sequenciador_banco.sv
// Access sequencer between the processor and the 8 x 8-bit register bank.
// Takes one instruction at a time, reads operands for the ULA, and writes
// the ULA result or an immediate back through the bank write port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// OCIOSO   | idle, InstrPronto = !Halt, accepts and decodes an instruction
// LEITURA  | bank read addresses valid, operands captured at the edge
// EXECUCAO | operands offered to the ULA, waits for ResultadoValido
// ESCRITA  | one-cycle write of RA with the latched data
// RETIRA   | retired-instruction counter increments
module sequenciador_banco
  import nrisc_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Halt,
  input  logic [7:0]         Instr,
  input  logic               InstrValido,
  output logic               InstrPronto,
  output logic [REG_W-1:0]   RegLido1,
  output logic [REG_W-1:0]   RegLido2,
  input  logic [LARGURA-1:0] Dado1,
  input  logic [LARGURA-1:0] Dado2,
  output logic [LARGURA-1:0] OperandoA,
  output logic [LARGURA-1:0] OperandoB,
  output logic               OperandosValido,
  input  logic [LARGURA-1:0] Resultado,
  input  logic               ResultadoValido,
  output logic               EscreveReg,
  output logic [REG_W-1:0]   RegEscrito,
  output logic [LARGURA-1:0] DadoEscrito,
  output logic [7:0]         ContInstr
);

  logic [1:0]       classeDec;
  logic [REG_W-1:0] raDec;
  logic [REG_W-1:0] rbDec;
  estado_t          estado;
  estado_t          estadoProx;
  logic             aceita;
  logic [REG_W-1:0] raReg;

  decodificador_instr uDecodificador (
    .Instr  (Instr),
    .Classe (classeDec),
    .Ra     (raDec),
    .Rb     (rbDec)
  );

  // Next-state selection and the state-derived handshake/write outputs
  always_comb begin
    estadoProx      = estado;
    InstrPronto     = 1'b0;
    OperandosValido = 1'b0;
    EscreveReg      = 1'b0;
    aceita          = 1'b0;
    case (estado)
      OCIOSO: begin
        InstrPronto = !Halt;
        if (InstrValido && !Halt) begin
          aceita = 1'b1;
          case (classeDec)
            CLASSE_ULA:  estadoProx = LEITURA;
            CLASSE_IMED: estadoProx = ESCRITA;
            default:     estadoProx = RETIRA;
          endcase
        end
      end
      LEITURA:  estadoProx = EXECUCAO;
      EXECUCAO: begin
        OperandosValido = 1'b1;
        if (ResultadoValido) estadoProx = ESCRITA;
      end
      ESCRITA: begin
        // A write stalled by Halt is replayed once Halt drops
        EscreveReg = !Halt;
        estadoProx = RETIRA;
      end
      RETIRA:   estadoProx = OCIOSO;
      default:  estadoProx = OCIOSO;
    endcase
  end

  // State register; Halt freezes the sequence, Reset overrides Halt
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado <= OCIOSO;
    end else if (!Halt) begin
      estado <= estadoProx;
    end
  end

  // Datapath registers: destination, read addresses, operands, write data, counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      raReg       <= '0;
      RegLido1    <= '0;
      RegLido2    <= '0;
      OperandoA   <= '0;
      OperandoB   <= '0;
      DadoEscrito <= '0;
      ContInstr   <= '0;
    end else if (!Halt) begin
      if (aceita) begin
        raReg <= raDec;
        // Addresses are loaded on accept so they are already valid during LEITURA
        if (classeDec == CLASSE_ULA) begin
          RegLido1 <= raDec;
          RegLido2 <= rbDec;
        end
        if (classeDec == CLASSE_IMED) begin
          DadoEscrito <= {{(LARGURA-REG_W){1'b0}}, rbDec};
        end
      end
      if (estado == LEITURA) begin
        OperandoA <= Dado1;
        OperandoB <= Dado2;
      end
      if (estado == EXECUCAO && ResultadoValido) begin
        DadoEscrito <= Resultado;
      end
      if (estado == RETIRA) begin
        ContInstr <= ContInstr + 8'd1;
      end
    end
  end

  assign RegEscrito = raReg;

endmodule

// File: tb/tb_sequenciador_banco.sv
// Scoreboard bench for sequenciador_banco: a bank model, a ULA responder
// (adder) and a reference model that predicts every bank write, its cycle,
// the operands offered to the ULA and the retired-instruction count.
module tb_sequenciador_banco;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         due;
  } wr_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Halt;
  logic [7:0] Instr;
  logic       InstrValido;
  logic       InstrPronto;
  logic [2:0] RegLido1;
  logic [2:0] RegLido2;
  logic [7:0] Dado1;
  logic [7:0] Dado2;
  logic [7:0] OperandoA;
  logic [7:0] OperandoB;
  logic       OperandosValido;
  logic [7:0] Resultado;
  logic       ResultadoValido;
  logic       EscreveReg;
  logic [2:0] RegEscrito;
  logic [7:0] DadoEscrito;
  logic [7:0] ContInstr;

  sequenciador_banco dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Halt            (Halt),
    .Instr           (Instr),
    .InstrValido     (InstrValido),
    .InstrPronto     (InstrPronto),
    .RegLido1        (RegLido1),
    .RegLido2        (RegLido2),
    .Dado1           (Dado1),
    .Dado2           (Dado2),
    .OperandoA       (OperandoA),
    .OperandoB       (OperandoB),
    .OperandosValido (OperandosValido),
    .Resultado       (Resultado),
    .ResultadoValido (ResultadoValido),
    .EscreveReg      (EscreveReg),
    .RegEscrito      (RegEscrito),
    .DadoEscrito     (DadoEscrito),
    .ContInstr       (ContInstr)
  );

  always #5 Clock = ~Clock;

  int nChk  = 0;
  int nPass = 0;
  int cyc   = 0;

  logic [7:0] envBank [8];
  logic [7:0] refBank [8];
  logic [7:0] savedBank [8];
  wr_t        wrQ[$];
  op_t        opQ[$];
  int         delayQ[$];
  int         expCnt = 0;
  logic [2:0] lastRa = 3'd0;
  logic [2:0] lastRb = 3'd0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    nChk++;
    if (ok) nPass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  always @(posedge Clock) cyc <= cyc + 1;

  // Bank: combinational reads, write on the rising edge
  assign Dado1 = envBank[RegLido1];
  assign Dado2 = envBank[RegLido2];
  always @(posedge Clock) if (EscreveReg) envBank[RegEscrito] <= DadoEscrito;

  // ULA responder: answers A+B after a per-instruction number of wait cycles
  int respWait = 0;
  bit respBusy = 1'b0;
  initial begin
    ResultadoValido = 1'b0;
    Resultado = 8'h00;
    forever begin
      @(negedge Clock);
      if (OperandosValido) begin
        if (!respBusy) begin
          respBusy = 1'b1;
          respWait = (delayQ.size() > 0) ? delayQ.pop_front() : 0;
        end
        if (respWait == 0) begin
          ResultadoValido = 1'b1;
          Resultado = OperandoA + OperandoB;
        end else begin
          ResultadoValido = 1'b0;
          respWait--;
        end
      end else begin
        ResultadoValido = 1'b0;
        respBusy = 1'b0;
      end
    end
  end

  // Monitor: compares DUT activity against the scoreboard queues
  bit prevPronto = 1'b0;
  bit prevOv = 1'b0;
  always @(negedge Clock) begin
    if (!Reset) begin
      if (EscreveReg) begin
        chk(wrQ.size() != 0, "write expected", 1, wrQ.size());
        if (wrQ.size() != 0) begin
          wr_t e;
          e = wrQ.pop_front();
          chk(RegEscrito == e.addr, "RegEscrito", RegEscrito, e.addr);
          chk(DadoEscrito == e.data, "DadoEscrito", DadoEscrito, e.data);
          chk(cyc == e.due, "write cycle", cyc, e.due);
        end
      end
      if (Halt) chk(EscreveReg == 1'b0, "EscreveReg under Halt", EscreveReg, 0);
      if (OperandosValido) begin
        chk(InstrPronto == 1'b0, "InstrPronto in EXECUCAO", InstrPronto, 0);
        if (opQ.size() != 0) begin
          chk(OperandoA == opQ[0].a, "OperandoA", OperandoA, opQ[0].a);
          chk(OperandoB == opQ[0].b, "OperandoB", OperandoB, opQ[0].b);
        end
      end else if (prevOv && opQ.size() != 0) begin
        void'(opQ.pop_front());
      end
      if (InstrPronto && !prevPronto)
        chk(ContInstr == 8'(expCnt), "ContInstr", ContInstr, expCnt % 256);
      prevPronto = InstrPronto;
      prevOv = OperandosValido;
    end else begin
      prevPronto = 1'b0;
      prevOv = 1'b0;
    end
  end

  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  // Presents one instruction, records the model's prediction at accept,
  // optionally holds Halt for h cycles right after the accept edge.
  task automatic issue(input logic [7:0] ins, input int dly, input int h);
    int g;
    int k;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] a;
    logic [7:0] b;
    step();
    Instr = ins;
    InstrValido = 1'b1;
    g = 0;
    while (!InstrPronto && g < 100) begin
      step();
      g++;
    end
    if (!InstrPronto) begin
      chk(InstrPronto == 1'b1, "accept timeout", InstrPronto, 1);
      InstrValido = 1'b0;
      return;
    end
    k = cyc;
    ra = ins[5:3];
    rb = ins[2:0];
    expCnt++;
    if (ins[7:6] == 2'b01) begin
      a = refBank[ra];
      b = refBank[rb];
      opQ.push_back('{a: a, b: b});
      delayQ.push_back(dly);
      wrQ.push_back('{addr: ra, data: 8'(a + b), due: k + 3 + dly + h});
      refBank[ra] = a + b;
      lastRa = ra;
      lastRb = rb;
    end else if (ins[7:6] == 2'b10) begin
      wrQ.push_back('{addr: ra, data: {5'b0, rb}, due: k + 1 + h});
      refBank[ra] = {5'b0, rb};
    end
    @(posedge Clock);
    #1;
    InstrValido = 1'b0;
    if (h > 0) begin
      Halt = 1'b1;
      repeat (h) @(posedge Clock);
      #1;
      Halt = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int g;
    g = 0;
    step();
    while (!InstrPronto && g < 200) begin
      step();
      g++;
    end
    chk(InstrPronto == 1'b1, "idle timeout", InstrPronto, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    int highs;
    int execCycles;
    logic [7:0] ins;

    Reset = 1'b1;
    Halt = 1'b0;
    Instr = 8'h00;
    InstrValido = 1'b0;
    for (int i = 0; i < 8; i++) begin
      envBank[i] = 8'($urandom);
      refBank[i] = envBank[i];
    end
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;

    chk(InstrPronto == 1'b1, "reset InstrPronto", InstrPronto, 1);
    chk(OperandosValido == 1'b0, "reset OperandosValido", OperandosValido, 0);
    chk(EscreveReg == 1'b0, "reset EscreveReg", EscreveReg, 0);
    chk(ContInstr == 8'h00, "reset ContInstr", ContInstr, 0);
    chk(DadoEscrito == 8'h00, "reset DadoEscrito", DadoEscrito, 0);
    chk(RegLido1 == 3'd0, "reset RegLido1", RegLido1, 0);

    // Reset in the middle of EXECUCAO abandons the instruction
    savedBank = refBank;
    issue(8'b01_011_100, 20, 0);
    g = 0;
    while (!OperandosValido && g < 20) begin
      step();
      g++;
    end
    step();
    chk(OperandosValido == 1'b1, "in EXECUCAO before reset", OperandosValido, 1);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    wrQ.delete();
    opQ.delete();
    delayQ.delete();
    refBank = savedBank;
    expCnt = 0;
    lastRa = 3'd0;
    lastRb = 3'd0;
    chk(OperandosValido == 1'b0, "post-reset OperandosValido", OperandosValido, 0);
    chk(InstrPronto == 1'b1, "post-reset InstrPronto", InstrPronto, 1);
    chk(EscreveReg == 1'b0, "post-reset EscreveReg", EscreveReg, 0);
    chk(ContInstr == 8'h00, "post-reset ContInstr", ContInstr, 0);
    chk(OperandoA == 8'h00, "post-reset OperandoA", OperandoA, 0);

    // 256 NOPs back to back: accepted every second cycle, counter wraps
    step();
    Instr = 8'h00;
    InstrValido = 1'b1;
    highs = 0;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) step();
      if (InstrPronto) begin
        highs++;
        expCnt++;
      end
    end
    InstrValido = 1'b0;
    chk(highs == 256, "NOP accept count", highs, 256);
    step();
    step();
    chk(ContInstr == 8'h00, "ContInstr wrap", ContInstr, 0);

    // ULA: r2 + r5, answer in the first EXECUCAO cycle
    envBank[2] = 8'h15; refBank[2] = 8'h15;
    envBank[5] = 8'h2A; refBank[5] = 8'h2A;
    issue(8'b01_010_101, 0, 0);
    waitIdle();
    chk(envBank[2] == 8'h3F, "bank r2 after ULA", envBank[2], 8'h3F);
    chk(ContInstr == 8'(expCnt), "ContInstr after ULA", ContInstr, expCnt % 256);

    // IMED: no read phase, read addresses keep their previous values
    issue(8'b10_111_110, 0, 0);
    waitIdle();
    chk(RegLido1 == lastRa, "RegLido1 held after IMED", RegLido1, lastRa);
    chk(RegLido2 == lastRb, "RegLido2 held after IMED", RegLido2, lastRb);
    chk(envBank[7] == 8'h06, "bank r7 after IMED", envBank[7], 8'h06);

    // ULA waits 5 extra cycles while another instruction is being offered
    issue(8'b01_001_110, 5, 0);
    Instr = 8'b10_000_111;
    InstrValido = 1'b1;
    g = 0;
    while (!OperandosValido && g < 20) begin
      step();
      g++;
    end
    execCycles = 0;
    while (OperandosValido && g < 40) begin
      execCycles++;
      step();
      g++;
    end
    InstrValido = 1'b0;
    chk(execCycles == 6, "EXECUCAO length", execCycles, 6);
    waitIdle();

    // Halt for 3 cycles while the IMED write is pending
    issue(8'b10_100_011, 0, 3);
    waitIdle();
    chk(envBank[4] == 8'h03, "bank r4 after halted write", envBank[4], 8'h03);

    // Random instruction mix with random ULA latency and occasional Halt
    for (int n = 0; n < 40; n++) begin
      ins = 8'($urandom);
      issue(ins, $urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
    end
    waitIdle();
    step();

    for (int i = 0; i < 8; i++)
      chk(envBank[i] == refBank[i], "final bank contents", envBank[i], refBank[i]);
    chk(wrQ.size() == 0, "pending writes", wrQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
